// File: rtl/noc_send_arbiter.sv
// noc_send_arbiter: shares one network send port between N_REQ local requesters.
// A round-robin arbiter loads a single hold register, and the held packet is
// emitted for exactly one cycle at the start of this node's TDMA slot.
module noc_send_arbiter #(
   parameter int N_REQ    = 4,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int N_NODES  = 8,
   parameter int SLOT_LEN = 4,
   parameter int NODE_ID  = 0,
   localparam int SLOT_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     send_valid,
   output logic [ADDR_W-1:0]        send_addr,
   output logic [DATA_W-1:0]        send_data,
   output logic [SLOT_W-1:0]        slot_idx,
   output logic                     pending
);

   localparam int CYC_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam int PTR_W = $clog2(N_REQ);
   localparam int IDX_W = PTR_W + 1;

   localparam logic [0:0] ST_EMPTY  = 1'b0;
   localparam logic [0:0] ST_LOADED = 1'b1;

   logic [0:0]        state_reg;
   logic [CYC_W-1:0]  cyc_cnt_reg;
   logic [SLOT_W-1:0] slot_reg;
   logic [PTR_W-1:0]  rr_ptr_reg;
   logic [ADDR_W-1:0] hold_addr_reg;
   logic [DATA_W-1:0] hold_data_reg;

   logic              slot_start;
   logic              grant_any;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  rr_ptr_next;
   logic [N_REQ-1:0]  grant;

   logic [ADDR_W-1:0] addr_arr [N_REQ];
   logic [DATA_W-1:0] data_arr [N_REQ];

   // Unpack the flat requester buses so the granted lane can be selected by index.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
   end

   // Free-running TDMA timebase: cycle within slot, then slot within frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_cnt_reg <= '0;
         slot_reg    <= '0;
      end else if (cyc_cnt_reg == CYC_W'(SLOT_LEN - 1)) begin
         cyc_cnt_reg <= '0;
         slot_reg    <= (slot_reg == SLOT_W'(N_NODES - 1)) ? '0 : slot_reg + 1'b1;
      end else begin
         cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
      end
   end

   assign slot_start = (slot_reg == SLOT_W'(NODE_ID)) && (cyc_cnt_reg == '0);

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      logic [IDX_W-1:0] idx;
      idx       = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr_ptr_reg} + IDX_W'(k);
         if (idx >= IDX_W'(N_REQ)) begin
            idx = idx - IDX_W'(N_REQ);
         end
         if (!grant_any && req_valid[idx[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = idx[PTR_W-1:0];
         end
      end
   end

   assign rr_ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // One-hot grant only while the hold register is free; forced low during reset.
   always_comb begin
      grant = '0;
      if (reset_n && grant_any && (state_reg == ST_EMPTY)) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // EMPTY/LOADED state, hold register capture and pointer advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_EMPTY;
         rr_ptr_reg    <= '0;
         hold_addr_reg <= '0;
         hold_data_reg <= '0;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (grant_any) begin
                  state_reg     <= ST_LOADED;
                  hold_addr_reg <= addr_arr[grant_idx];
                  hold_data_reg <= data_arr[grant_idx];
                  rr_ptr_reg    <= rr_ptr_next;
               end
            end
            ST_LOADED: begin
               if (slot_start) begin
                  state_reg <= ST_EMPTY;
               end
            end
            default: state_reg <= ST_EMPTY;
         endcase
      end
   end

   // Send side decodes only registered state and the timebase.
   assign pending    = (state_reg == ST_LOADED);
   assign send_valid = pending && slot_start;
   assign send_addr  = send_valid ? hold_addr_reg : '0;
   assign send_data  = send_valid ? hold_data_reg : '0;
   assign req_ready  = grant;
   assign slot_idx   = slot_reg;

endmodule

// File: tb/tb_noc_send_arbiter.sv
// Testbench for noc_send_arbiter: scenario tasks plus a time-based reference
// model (slot position derived from absolute cycle number since reset).
module tb_noc_send_arbiter;

   localparam int N_REQ    = 4;
   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int N_NODES  = 4;
   localparam int SLOT_LEN = 4;
   localparam int NODE_ID  = 2;
   localparam int FRAME    = N_NODES * SLOT_LEN;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic [N_REQ-1:0]        req_valid = '0;
   logic [N_REQ*ADDR_W-1:0] req_addr = '0;
   logic [N_REQ*DATA_W-1:0] req_data = '0;
   logic [N_REQ-1:0]        req_ready;
   logic                    send_valid;
   logic [ADDR_W-1:0]       send_addr;
   logic [DATA_W-1:0]       send_data;
   logic [1:0]              slot_idx;
   logic                    pending;

   noc_send_arbiter #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .N_NODES(N_NODES), .SLOT_LEN(SLOT_LEN), .NODE_ID(NODE_ID)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .send_valid(send_valid), .send_addr(send_addr),
      .send_data(send_data), .slot_idx(slot_idx), .pending(pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int          m_t;
   bit          m_rst;
   bit          m_pending;
   logic [7:0]  m_haddr;
   logic [31:0] m_hdata;
   int          m_ptr;

   logic [47:0] exp_vec;
   logic [47:0] dut_vec;
   assign dut_vec = {req_ready, send_valid, send_addr, send_data, slot_idx, pending};

   function automatic int first_valid(int ptr, logic [3:0] v);
      for (int k = 0; k < N_REQ; k++) begin
         int j;
         j = (ptr + k) % N_REQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(logic [3:0] v);
      for (int k = 0; k < N_REQ; k++) if (v[k]) return k;
      return -1;
   endfunction

   function automatic bit is_slot_start(int t);
      return (t % FRAME) == NODE_ID * SLOT_LEN;
   endfunction

   task automatic model_eval();
      logic [3:0]  e_ready;
      logic        e_sv;
      logic [7:0]  e_addr;
      logic [31:0] e_data;
      logic [1:0]  e_slot;
      int g;
      e_ready = '0; e_sv = 1'b0; e_addr = '0; e_data = '0; e_slot = '0;
      if (!m_rst) begin
         e_slot = 2'((m_t / SLOT_LEN) % N_NODES);
         g = first_valid(m_ptr, req_valid);
         if (!m_pending && g >= 0) e_ready[g] = 1'b1;
         if (m_pending && is_slot_start(m_t)) begin
            e_sv = 1'b1; e_addr = m_haddr; e_data = m_hdata;
         end
      end
      exp_vec = {e_ready, e_sv, e_addr, e_data, e_slot, (m_rst ? 1'b0 : m_pending)};
   endtask

   task automatic model_commit();
      int g;
      if (m_rst) return;
      g = first_valid(m_ptr, req_valid);
      if (m_pending) begin
         if (is_slot_start(m_t)) m_pending = 1'b0;
      end else if (g >= 0) begin
         m_pending = 1'b1;
         m_haddr   = req_addr[g*ADDR_W +: ADDR_W];
         m_hdata   = req_data[g*DATA_W +: DATA_W];
         m_ptr     = (g + 1) % N_REQ;
      end
      m_t++;
   endtask

   task automatic model_clear();
      m_t = 0; m_pending = 1'b0; m_haddr = '0; m_hdata = '0; m_ptr = 0;
   endtask

   // Mid-cycle sample point; prints one line per observed transaction.
   task automatic settle();
      @(negedge clk);
      model_eval();
      if (|req_ready) $display("grant t=%0d req=%0d", m_t, onehot_idx(req_ready));
      if (send_valid) $display("send  t=%0d addr=%h data=%h", m_t, send_addr, send_data);
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic set_req(int i, bit v, logic [7:0] a, logic [31:0] d);
      req_valid[i] = v;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   // Asserts reset, holds two edges, releases just after an edge: that cycle is cycle 0.
   task automatic do_reset();
      reset_n = 1'b0; m_rst = 1'b1; model_clear();
      req_valid = '0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1; m_rst = 1'b0; model_clear();
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      reset_n = 1'b0; m_rst = 1'b1; model_clear();
      #1;
      n_checks++;
      if (dut_vec !== 48'h0) begin
         n_errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 48'h0);
      end
      @(posedge clk); @(posedge clk); #1;
      req_valid = '0;
      reset_n = 1'b1; m_rst = 1'b0; model_clear();
      for (int c = 0; c < 3; c++) begin
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL reset_after t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (c == 0) begin
            n_checks++;
            if (slot_idx !== 2'd0 || pending !== 1'b0) begin
               n_errors++; $display("FAIL reset_cycle0 slot=%0d pend=%b exp slot=0 pend=0", slot_idx, pending);
            end
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 0; c < 11; c++) begin
         set_req(0, (c == 1), 8'h05, 32'hDEADBEEF);
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL single t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (c == 1) begin
            n_checks++;
            if (req_ready !== 4'b0001) begin
               n_errors++; $display("FAIL single_grant got=%b exp=0001", req_ready);
            end
         end
         if (c == 2) begin
            n_checks++;
            if (pending !== 1'b1) begin
               n_errors++; $display("FAIL single_pending got=%b exp=1", pending);
            end
         end
         if (c == 8) begin
            n_checks++;
            if ({send_valid, send_addr, send_data} !== {1'b1, 8'h05, 32'hDEADBEEF}) begin
               n_errors++; $display("FAIL single_send got=%b/%h/%h exp=1/05/deadbeef", send_valid, send_addr, send_data);
            end
         end
         if (c == 9) begin
            n_checks++;
            if (send_valid !== 1'b0 || pending !== 1'b0) begin
               n_errors++; $display("FAIL single_after got sv=%b pend=%b exp 0/0", send_valid, pending);
            end
         end
         tick();
      end
   endtask

   task automatic test_contention();
      int gq[$];
      int gt[$];
      int sq[$];
      int exp_g[5] = '{0, 1, 2, 3, 0};
      int exp_t[5] = '{0, 9, 25, 41, 57};
      int exp_s[4] = '{8, 24, 40, 56};
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 8'(8'h10 + i), 32'hC0DE_0000 + i);
      for (int c = 0; c < 61; c++) begin
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL contention t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (|req_ready) begin gq.push_back(onehot_idx(req_ready)); gt.push_back(c); end
         if (send_valid) sq.push_back(c);
         tick();
      end
      n_checks++;
      if (gq.size() != 5 || sq.size() != 4) begin
         n_errors++; $display("FAIL contention_counts grants=%0d sends=%0d exp 5/4", gq.size(), sq.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (gq[k] != exp_g[k] || gt[k] != exp_t[k]) begin
               n_errors++; $display("FAIL contention_grant%0d got req%0d@%0d exp req%0d@%0d", k, gq[k], gt[k], exp_g[k], exp_t[k]);
            end
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (sq[k] != exp_s[k]) begin
               n_errors++; $display("FAIL contention_send%0d got=%0d exp=%0d", k, sq[k], exp_s[k]);
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_pointer_skip();
      int gq[$];
      int gt[$];
      int exp_g[3] = '{3, 1, 3};
      int exp_t[3] = '{0, 9, 25};
      do_reset();
      for (int c = 0; c < 30; c++) begin
         set_req(3, 1'b1, 8'h33, 32'h3333_0000 + c);
         set_req(1, (c >= 1), 8'h11, 32'h1111_0000 + c);
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL ptr_skip t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (|req_ready) begin gq.push_back(onehot_idx(req_ready)); gt.push_back(c); end
         tick();
      end
      n_checks++;
      if (gq.size() != 3) begin
         n_errors++; $display("FAIL ptr_skip_count got=%0d exp=3", gq.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (gq[k] != exp_g[k] || gt[k] != exp_t[k]) begin
               n_errors++; $display("FAIL ptr_skip_grant%0d got req%0d@%0d exp req%0d@%0d", k, gq[k], gt[k], exp_g[k], exp_t[k]);
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_slot_boundary();
      do_reset();
      for (int c = 0; c < 42; c++) begin
         set_req(2, (c == 24), 8'hA1, 32'h12345678);
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL boundary t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (c == 24) begin
            n_checks++;
            if (req_ready !== 4'b0100 || send_valid !== 1'b0) begin
               n_errors++; $display("FAIL boundary_grant got ready=%b sv=%b exp 0100/0", req_ready, send_valid);
            end
         end
         if (c == 40) begin
            n_checks++;
            if ({send_valid, send_addr, send_data} !== {1'b1, 8'hA1, 32'h12345678}) begin
               n_errors++; $display("FAIL boundary_send got=%b/%h/%h exp=1/a1/12345678", send_valid, send_addr, send_data);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         set_req(0, (c == 1), 8'h0A, 32'hAAAA_0001);
         set_req(1, (c >= 1 && c <= 9), 8'h0B, 32'hBBBB_0002);
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL backpressure t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (c >= 2 && c <= 8) begin
            n_checks++;
            if (req_ready[1] !== 1'b0) begin
               n_errors++; $display("FAIL backpressure_hold t=%0d got=%b exp=0", c, req_ready[1]);
            end
         end
         if (c == 9) begin
            n_checks++;
            if (req_ready[1] !== 1'b1) begin
               n_errors++; $display("FAIL backpressure_release got=%b exp=1", req_ready[1]);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         set_req(0, (c == 1), 8'h77, 32'h7777_7777);
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL midhold_pre t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         tick();
      end
      // Cycle 6: packet is held; reset lands between edges with all requesters valid.
      n_checks++;
      if (pending !== 1'b1) begin
         n_errors++; $display("FAIL midhold_loaded got=%b exp=1", pending);
      end
      req_valid = 4'b1111;
      reset_n = 1'b0; m_rst = 1'b1; model_clear();
      #1;
      n_checks++;
      if (dut_vec !== 48'h0) begin
         n_errors++; $display("FAIL midhold_async got=%h exp=%h", dut_vec, 48'h0);
      end
      @(posedge clk); @(posedge clk); #1;
      req_valid = '0;
      reset_n = 1'b1; m_rst = 1'b0; model_clear();
      for (int c = 0; c < 20; c++) begin
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL midhold_post t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         if (c == 0 || c == 8) begin
            n_checks++;
            if (send_valid !== 1'b0 || (c == 0 && slot_idx !== 2'd0)) begin
               n_errors++; $display("FAIL midhold_quiet t=%0d got sv=%b slot=%0d exp sv=0", c, send_valid, slot_idx);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N_REQ; i++) begin
            set_req(i, ($urandom_range(0, 3) == 0), 8'($urandom), 32'($urandom));
         end
         settle();
         n_checks++;
         if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL random t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec);
         end
         tick();
      end
      req_valid = '0;
   endtask

   initial begin
      m_rst = 1'b1;
      model_clear();
      test_reset();
      test_single();
      test_contention();
      test_pointer_skip();
      test_slot_boundary();
      test_back_pressure();
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/noc_send_arbiter.md
# noc_send_arbiter

Round-robin arbiter and TDMA slot scheduler for the node's network send channel (8-bit destination address, 32-bit payload). It shares one send port between N_REQ local requesters, such as the Nios send PIO and hardware accelerators. It holds at most one granted packet and emits it for one cycle at the start of this node's TDMA slot. It sits between the processor-side PIO adapters and the network interface.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, destination address width
- DATA_W, 32, payload width
- N_NODES, 8, TDMA slots per frame
- SLOT_LEN, 4, cycles per slot; N_NODES*SLOT_LEN >= 2
- NODE_ID, 0, this node's slot index; must be < N_NODES
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester packet valid
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  packed payloads, same packing
- req_ready  out  N_REQ  one-hot grant; transfer = req_valid[i] & req_ready[i]
- send_valid  out  1  packet on send bus this cycle
- send_addr  out  ADDR_W  destination; 0 when send_valid=0
- send_data  out  DATA_W  payload; 0 when send_valid=0
- slot_idx  out  clog2(N_NODES)  current TDMA slot
- pending  out  1  hold register loaded

## Operation
- Counters: cyc_cnt counts 0..SLOT_LEN-1 and wraps. On wrap, slot_idx increments 0..N_NODES-1 and wraps. Both free-run from reset.
- slot_start = (slot_idx==NODE_ID) && (cyc_cnt==0).
- State machine has two states, EMPTY and LOADED. The state register is visible as pending (1 = LOADED).
- EMPTY:
  - If any req_valid is set, req_ready is one-hot for the first valid requester found searching from rr_ptr upward, modulo N_REQ. All other bits are 0.
  - On that transfer, the address and data are captured into the hold register, the state goes to LOADED, and rr_ptr becomes (granted+1) mod N_REQ.
  - No valid requester: req_ready=0, state stays EMPTY.
- LOADED:
  - req_ready=0.
  - On slot_start: send_valid=1 with the hold contents, then the state goes to EMPTY on the next edge.
- req_ready is combinational from state, rr_ptr and req_valid. Requesters must not make req_valid depend on req_ready.
- Exactly one packet per frame at most. send_valid is never high outside slot_start.
- Simultaneous events:
  - A request arriving in EMPTY during a slot_start cycle is granted that cycle. It is emitted at the next frame's slot_start, not the current one.
  - In the emission cycle the state is still LOADED, so no grant happens. The earliest next grant is the following cycle.
- Requester behaviour is not checked. A requester dropping valid without a grant is legal; nothing is latched for it.
- Reset (asynchronous, any time):
  - Outputs: send_valid=0, send_addr=0, send_data=0, req_ready=0, slot_idx=0, pending=0.
  - Internal: cyc_cnt=0, rr_ptr=0, hold register cleared.
  - A held packet is discarded.

## Timing
- Cycle 0 is the first cycle after reset_n deasserts. Slot start for this node is at cycle NODE_ID*SLOT_LEN + k*N_NODES*SLOT_LEN.
- Grant-to-hold latency: the packet is captured on the edge ending the grant cycle.
- Hold-to-send latency: up to one frame (N_NODES*SLOT_LEN cycles).
- send_valid is high for exactly one cycle per emission.
- Outputs decode registered state and counters only; there is no combinational path from req_* to send_*.
- Throughput: one packet per frame. Back-pressure is expressed only through req_ready.

## Test plan
Configuration for all scenarios: N_REQ=4, N_NODES=4, SLOT_LEN=4, NODE_ID=2, so frame = 16 cycles and slot_start falls at cycles 8, 24, 40, …

- Single request after reset:
  - Stimulus: req0 valid at cycle 1 with addr 0x05, data 0xDEADBEEF.
  - Required: req_ready[0]=1 in cycle 1; pending=1 from cycle 2; send_valid=1 at cycle 8 with 0x05/0xDEADBEEF; send_valid=0 and pending=0 at cycle 9.
- Full contention:
  - Stimulus: all four requesters valid continuously from cycle 0.
  - Required: grants in order 0 (cycle 0), 1 (cycle 9), 2 (cycle 25), 3 (cycle 41), 0 (cycle 57); send_valid only at cycles 8, 24, 40, 56.
- Pointer skip:
  - Stimulus: after a grant to requester 3, only req1 and req3 are valid.
  - Required: req1 is granted, then rr_ptr=2. The next grant goes to req3.
- Boundary at slot start:
  - Stimulus: state EMPTY, req2 asserted first at cycle 24, with addr 0xA1, data 0x12345678.
  - Required: req_ready[2]=1 at cycle 24; no send at cycle 24; send at cycle 40 with 0xA1/0x12345678.
- Back-pressure:
  - Stimulus: req1 valid continuously while pending=1 (loaded at cycle 2).
  - Required: req_ready[1]=0 for cycles 2–8; req_ready[1]=1 at cycle 9.
- Reset mid-hold:
  - Stimulus: packet held at cycle 5; assert reset_n=0 at cycle 6 for 2 cycles.
  - Required: all outputs 0 immediately, without waiting for a clock edge. After release, no send_valid until a new grant. slot_idx restarts at 0.
